// File: rtl/mcu_el2_pkg.sv
// Shared types for the debug trigger block: matcher packet, stored tdata1 fields,
// the arbitrated write request, and the tdata1 read-image builder.
package mcu_el2_pkg;

  localparam int TD1_DMODE   = 27;
  localparam int TD1_HIT     = 20;
  localparam int TD1_SELECT  = 19;
  localparam int TD1_ACTION  = 12;
  localparam int TD1_CHAIN   = 11;
  localparam int TD1_MATCH   = 7;
  localparam int TD1_M       = 6;
  localparam int TD1_EXECUTE = 2;
  localparam int TD1_STORE   = 1;
  localparam int TD1_LOAD    = 0;

  localparam logic [3:0] TRIG_TYPE_MCONTROL = 4'd2;

  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } mcu_el2_trigger_pkt_t;

  typedef struct packed {
    logic dmode;
    logic hit;
    logic select;
    logic action;
    logic chain;
    logic match;
    logic m;
    logic execute;
    logic store;
    logic load;
  } trig_tdata1_t;

  typedef struct packed {
    logic        vld;
    logic        dbg;
    logic [1:0]  sel;
    logic        regsel;
    logic [31:0] data;
  } trig_wr_req_t;

  // Unimplemented bits read as zero; type and maskmax are constants.
  function automatic logic [31:0] tdata1_pack(trig_tdata1_t t, logic [5:0] maskmax);
    logic [31:0] v;
    v              = '0;
    v[31:28]       = TRIG_TYPE_MCONTROL;
    v[TD1_DMODE]   = t.dmode;
    v[26:21]       = maskmax;
    v[TD1_HIT]     = t.hit;
    v[TD1_SELECT]  = t.select;
    v[TD1_ACTION]  = t.action;
    v[TD1_CHAIN]   = t.chain;
    v[TD1_MATCH]   = t.match;
    v[TD1_M]       = t.m;
    v[TD1_EXECUTE] = t.execute;
    v[TD1_STORE]   = t.store;
    v[TD1_LOAD]    = t.load;
    return v;
  endfunction

endpackage

// File: rtl/mcu_el2_dec_trigger_ctl_if.sv
// Trigger CSR write port: core and debug-module requesters plus the drop indication.
interface mcu_el2_dec_trigger_ctl_if;

  logic        core_wr_valid;
  logic        core_wr_ready;
  logic [1:0]  core_wr_sel;
  logic        core_wr_reg;
  logic [31:0] core_wr_data;

  logic        dbg_wr_valid;
  logic        dbg_wr_ready;
  logic [1:0]  dbg_wr_sel;
  logic        dbg_wr_reg;
  logic [31:0] dbg_wr_data;

  logic        wr_err;

  modport master (
    output core_wr_valid, core_wr_sel, core_wr_reg, core_wr_data,
    output dbg_wr_valid, dbg_wr_sel, dbg_wr_reg, dbg_wr_data,
    input  core_wr_ready, dbg_wr_ready, wr_err
  );

  modport slave (
    input  core_wr_valid, core_wr_sel, core_wr_reg, core_wr_data,
    input  dbg_wr_valid, dbg_wr_sel, dbg_wr_reg, dbg_wr_data,
    output core_wr_ready, dbg_wr_ready, wr_err
  );

endinterface

// File: rtl/mcu_el2_trig_slot.sv
// One trigger register set: tdata1 fields plus tdata2, with dmode lock,
// write legalisation and hit-bit set (an accepted tdata1 write beats the hit set).
module mcu_el2_trig_slot
  import mcu_el2_pkg::*;
#(
  parameter bit CHAIN_OK = 1'b1
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         wr_en,
  input  logic         wr_dbg,
  input  logic         wr_reg,
  input  logic [31:0]  wr_data,
  input  logic         partner_dmode,
  input  logic         fire,
  output trig_tdata1_t tdata1,
  output logic [31:0]  tdata2,
  output logic         wr_drop
);

  trig_tdata1_t td1_q, td1_d, td1_wr;
  logic [31:0]  td2_q, td2_d;
  logic         wr_ok;

  // Only the debug module may touch a dmode-owned trigger.
  assign wr_drop = wr_en & td1_q.dmode & ~wr_dbg;
  assign wr_ok   = wr_en & ~wr_drop;

  always_comb begin
    td1_wr         = '0;
    td1_wr.dmode   = wr_dbg & wr_data[TD1_DMODE];
    td1_wr.hit     = wr_data[TD1_HIT];
    td1_wr.select  = wr_data[TD1_SELECT];
    td1_wr.action  = td1_wr.dmode & wr_data[TD1_ACTION];
    // A non-debug even trigger may not chain onto a debug-owned odd partner.
    td1_wr.chain   = CHAIN_OK & wr_data[TD1_CHAIN] & ~(partner_dmode & ~td1_wr.dmode);
    td1_wr.match   = wr_data[TD1_MATCH];
    td1_wr.m       = wr_data[TD1_M];
    td1_wr.execute = wr_data[TD1_EXECUTE];
    td1_wr.store   = wr_data[TD1_STORE];
    td1_wr.load    = wr_data[TD1_LOAD];
  end

  always_comb begin
    td1_d = td1_q;
    td2_d = td2_q;
    if (fire)
      td1_d.hit = 1'b1;
    if (wr_ok & ~wr_reg)
      td1_d = td1_wr;
    if (wr_ok & wr_reg)
      td2_d = wr_data;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      td1_q <= '0;
      td2_q <= '0;
    end else begin
      td1_q <= td1_d;
      td2_q <= td2_d;
    end
  end

  assign tdata1 = td1_q;
  assign tdata2 = td2_q;

endmodule

// File: rtl/mcu_el2_dec_trigger_ctl.sv
// Debug trigger control: CSR write arbitration (debug first), per-trigger register
// slots, R-stage match register, pairwise chaining, hit set and action resolution.
module mcu_el2_dec_trigger_ctl
  import mcu_el2_pkg::*;
#(
  parameter int NTRIG   = 4,
  parameter int MASKMAX = 31
) (
  input  logic                             clk,
  input  logic                             rst_l,
  mcu_el2_dec_trigger_ctl_if.slave         wr_if,
  input  logic [1:0]                       rd_sel,
  input  logic                             rd_reg,
  output logic [31:0]                      rd_data,
  output mcu_el2_trigger_pkt_t [NTRIG-1:0] trigger_pkt_any,
  input  logic [NTRIG-1:0]                 i0_trigger_match_d,
  input  logic                             i0_valid_d,
  input  logic                             i0_flush_r,
  output logic [NTRIG-1:0]                 trigger_fire_r,
  output logic                             trigger_action_dbg,
  output logic                             trigger_action_brk
);

  localparam logic [5:0] MASKMAX_F = 6'(MASKMAX);

  trig_wr_req_t                   req;
  trig_tdata1_t [NTRIG-1:0]       td1;
  logic         [NTRIG-1:0][31:0] td2;
  logic         [NTRIG-1:0][31:0] td1_rd;
  logic         [NTRIG-1:0]       wr_drop;
  logic         [NTRIG-1:0]       chain, action;
  logic         [NTRIG-1:0]       match_r_q, match_r_d;
  logic         [NTRIG-1:0]       fire;

  // Readies are held low while in reset so nothing looks accepted.
  assign wr_if.dbg_wr_ready  = wr_if.dbg_wr_valid & rst_l;
  assign wr_if.core_wr_ready = wr_if.core_wr_valid & ~wr_if.dbg_wr_valid & rst_l;

  always_comb begin
    req        = '0;
    req.vld    = wr_if.dbg_wr_valid | wr_if.core_wr_valid;
    req.dbg    = wr_if.dbg_wr_valid;
    req.sel    = wr_if.dbg_wr_valid ? wr_if.dbg_wr_sel  : wr_if.core_wr_sel;
    req.regsel = wr_if.dbg_wr_valid ? wr_if.dbg_wr_reg  : wr_if.core_wr_reg;
    req.data   = wr_if.dbg_wr_valid ? wr_if.dbg_wr_data : wr_if.core_wr_data;
  end

  assign wr_if.wr_err = |wr_drop;

  for (genvar i = 0; i < NTRIG; i++) begin : g_slot
    mcu_el2_trig_slot #(
      .CHAIN_OK ((i % 2) == 0)
    ) u_slot (
      .clk           (clk),
      .rst_l         (rst_l),
      .wr_en         (req.vld & (req.sel == 2'(i))),
      .wr_dbg        (req.dbg),
      .wr_reg        (req.regsel),
      .wr_data       (req.data),
      .partner_dmode (td1[i ^ 1].dmode),
      .fire          (trigger_fire_r[i]),
      .tdata1        (td1[i]),
      .tdata2        (td2[i]),
      .wr_drop       (wr_drop[i])
    );

    assign td1_rd[i] = tdata1_pack(td1[i], MASKMAX_F);
    assign chain[i]  = td1[i].chain;
    assign action[i] = td1[i].action;

    assign trigger_pkt_any[i].select  = td1[i].select;
    assign trigger_pkt_any[i].match   = td1[i].match;
    assign trigger_pkt_any[i].store   = td1[i].store;
    assign trigger_pkt_any[i].load    = td1[i].load;
    assign trigger_pkt_any[i].execute = td1[i].execute;
    assign trigger_pkt_any[i].m       = td1[i].m;
    assign trigger_pkt_any[i].tdata2  = td2[i];
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NTRIG; i++)
      if (rd_sel == 2'(i))
        rd_data = rd_reg ? td2[i] : td1_rd[i];
  end

  assign match_r_d = i0_trigger_match_d & {NTRIG{i0_valid_d}};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      match_r_q <= '0;
    else
      match_r_q <= match_r_d;
  end

  // A chained pair fires together only when both halves matched.
  for (genvar p = 0; p < NTRIG / 2; p++) begin : g_pair
    logic both;
    assign both          = match_r_q[2*p] & match_r_q[2*p+1];
    assign fire[2*p]     = chain[2*p] ? both : match_r_q[2*p];
    assign fire[2*p+1]   = chain[2*p] ? both : match_r_q[2*p+1];
  end

  assign trigger_fire_r     = fire & ~{NTRIG{i0_flush_r}};
  assign trigger_action_dbg = |(trigger_fire_r & action);
  assign trigger_action_brk = |trigger_fire_r & ~trigger_action_dbg;

endmodule

// File: tb/tb_mcu_el2_dec_trigger_ctl.sv
// Bench for the trigger control block: directed write table, hand sequences for
// chaining/flush/hit corners, and a randomized run against a register-image model.
module tb_mcu_el2_dec_trigger_ctl;
  import mcu_el2_pkg::*;

  localparam logic [31:0] RO   = 32'h23E0_0000;
  localparam logic [31:0] WMSK = 32'h0818_18C7;

  logic                          clk = 1'b0;
  logic                          rst_l;
  logic [1:0]                    rd_sel;
  logic                          rd_reg;
  logic [31:0]                   rd_data;
  mcu_el2_trigger_pkt_t [3:0]    pkt;
  logic [3:0]                    mtch, fire;
  logic                          vld, flush, adbg, abrk;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mcu_el2_dec_trigger_ctl_if wif ();

  mcu_el2_dec_trigger_ctl #(.NTRIG(4), .MASKMAX(31)) u_dut (
    .clk                (clk),
    .rst_l              (rst_l),
    .wr_if              (wif),
    .rd_sel             (rd_sel),
    .rd_reg             (rd_reg),
    .rd_data            (rd_data),
    .trigger_pkt_any    (pkt),
    .i0_trigger_match_d (mtch),
    .i0_valid_d         (vld),
    .i0_flush_r         (flush),
    .trigger_fire_r     (fire),
    .trigger_action_dbg (adbg),
    .trigger_action_brk (abrk)
  );

  typedef struct {
    logic        dv;
    logic [1:0]  ds;
    logic        dr;
    logic [31:0] dd;
    logic        cv;
    logic [1:0]  cs;
    logic        cr;
    logic [31:0] cd;
    logic [1:0]  rs;
    logic        rr;
    logic [2:0]  e_hs;  // {dbg_ready, core_ready, wr_err}
    logic [31:0] e_rd;
  } wvec_t;

  wvec_t tbl[13];

  logic [31:0] m_t1[4];
  logic [31:0] m_t2[4];
  logic [3:0]  m_mr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wif.dbg_wr_valid  = 1'b0; wif.dbg_wr_sel  = '0; wif.dbg_wr_reg  = 1'b0; wif.dbg_wr_data  = '0;
    wif.core_wr_valid = 1'b0; wif.core_wr_sel = '0; wif.core_wr_reg = 1'b0; wif.core_wr_data = '0;
    mtch = '0; vld = 1'b0; flush = 1'b0; rd_sel = '0; rd_reg = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic wr1(input logic is_dbg, input logic [1:0] s, input logic r, input logic [31:0] d);
    step();
    if (is_dbg) begin
      wif.dbg_wr_valid = 1'b1; wif.dbg_wr_sel = s; wif.dbg_wr_reg = r; wif.dbg_wr_data = d;
    end else begin
      wif.core_wr_valid = 1'b1; wif.core_wr_sel = s; wif.core_wr_reg = r; wif.core_wr_data = d;
    end
  endtask

  function automatic wvec_t mk(logic dv, logic [1:0] ds, logic dr, logic [31:0] dd,
                               logic cv, logic [1:0] cs, logic cr, logic [31:0] cd,
                               logic [1:0] rs, logic rr, logic [2:0] e_hs, logic [31:0] e_rd);
    wvec_t v;
    v.dv = dv; v.ds = ds; v.dr = dr; v.dd = dd;
    v.cv = cv; v.cs = cs; v.cr = cr; v.cd = cd;
    v.rs = rs; v.rr = rr; v.e_hs = e_hs; v.e_rd = e_rd;
    return v;
  endfunction

  // Randomized-phase scratch
  logic        r_dv, r_cv, g_v, g_dbg, g_r, e_err, e_dbg, e_brk;
  logic [31:0] g_d, v1, e_rd;
  logic [3:0]  f, fr;
  int          gs, k, w1;

  initial begin
    tbl[0]  = mk(1, 0, 0, 32'h0800_1044, 0, 0, 0, 0,            0, 0, 3'b100, 32'h2BE0_1044);
    tbl[1]  = mk(0, 0, 0, 0,             1, 0, 0, 32'h0000_0005, 0, 0, 3'b011, 32'h2BE0_1044);
    tbl[2]  = mk(0, 0, 0, 0,             1, 0, 1, 32'h0000_1234, 0, 1, 3'b011, 32'h0000_0000);
    tbl[3]  = mk(0, 0, 0, 0,             1, 1, 0, 32'h0800_1840, 1, 0, 3'b010, 32'h23E0_0040);
    tbl[4]  = mk(1, 1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0,            1, 1, 3'b100, 32'hDEAD_BEEF);
    tbl[5]  = mk(1, 2, 0, 32'h0000_0885, 1, 3, 0, 32'h0000_0004, 2, 0, 3'b100, 32'h23E0_0885);
    tbl[6]  = mk(0, 0, 0, 0,             1, 3, 0, 32'h0000_0004, 3, 0, 3'b010, 32'h23E0_0004);
    tbl[7]  = mk(1, 3, 0, 32'h0800_0000, 0, 0, 0, 0,            3, 0, 3'b100, 32'h2BE0_0000);
    tbl[8]  = mk(0, 0, 0, 0,             1, 2, 0, 32'h0000_0800, 2, 0, 3'b010, 32'h23E0_0000);
    tbl[9]  = mk(1, 2, 0, 32'h0800_1800, 0, 0, 0, 0,            2, 0, 3'b100, 32'h2BE0_1800);
    tbl[10] = mk(0, 0, 0, 0,             1, 3, 1, 32'h0000_0055, 3, 1, 3'b011, 32'h0000_0000);
    tbl[11] = mk(1, 0, 0, 32'h0000_1044, 0, 0, 0, 0,            0, 0, 3'b100, 32'h23E0_0044);
    tbl[12] = mk(0, 0, 0, 0,             1, 0, 0, 32'h0010_1000, 0, 0, 3'b010, 32'h23F0_0000);

    // Reset state, with both requesters asserting
    rst_l = 1'b0;
    idle();
    wif.dbg_wr_valid = 1'b1; wif.core_wr_valid = 1'b1;
    mtch = 4'hF; vld = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_handshake", {wif.dbg_wr_ready, wif.core_wr_ready, wif.wr_err}, 3'b000);
    chk("rst_fire", {fire, adbg, abrk}, 6'd0);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); rd_reg = 1'b0; #1;
      chk("rst_tdata1", rd_data, RO);
      rd_reg = 1'b1; #1;
      chk("rst_tdata2", rd_data, 32'd0);
    end
    step();
    rst_l = 1'b1;

    // Directed write/readback table
    for (int i = 0; i < 13; i++) begin
      step();
      wif.dbg_wr_valid  = tbl[i].dv; wif.dbg_wr_sel  = tbl[i].ds;
      wif.dbg_wr_reg    = tbl[i].dr; wif.dbg_wr_data = tbl[i].dd;
      wif.core_wr_valid = tbl[i].cv; wif.core_wr_sel = tbl[i].cs;
      wif.core_wr_reg   = tbl[i].cr; wif.core_wr_data = tbl[i].cd;
      #1;
      chk($sformatf("tbl%0d_handshake", i), {wif.dbg_wr_ready, wif.core_wr_ready, wif.wr_err}, tbl[i].e_hs);
      step();
      rd_sel = tbl[i].rs; rd_reg = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d_readback", i), rd_data, tbl[i].e_rd);
    end

    // Chained pair 0/1: one half alone must not fire
    wr1(1, 0, 0, 32'h0000_0804);
    wr1(1, 1, 0, 32'h0000_0004);
    step(); mtch = 4'b0001; vld = 1'b1;
    step(); #1;
    chk("chain_half_fire", {fire, adbg, abrk}, 6'b0000_00);
    step(); mtch = 4'b0011; vld = 1'b1;
    step(); #1;
    chk("chain_both_fire", {fire, adbg, abrk}, 6'b0011_01);
    step(); rd_sel = 2'd0; #1;
    chk("chain_hit0", rd_data[20], 1'b1);
    step(); rd_sel = 2'd1; #1;
    chk("chain_hit1", rd_data[20], 1'b1);

    // Trigger 2 breakpoint, then the same match killed by flush
    wr1(1, 2, 0, 32'h0000_0004);
    step(); mtch = 4'b0100; vld = 1'b1;
    step(); #1;
    chk("t2_brk", {fire, adbg, abrk}, 6'b0100_01);
    step(); rd_sel = 2'd2; #1;
    chk("t2_hit_set", rd_data[20], 1'b1);
    wr1(1, 2, 0, 32'h0000_0004);
    step(); mtch = 4'b0100; vld = 1'b1;
    step(); flush = 1'b1; #1;
    chk("t2_flushed", {fire, adbg, abrk}, 6'b0000_00);
    step(); rd_sel = 2'd2; #1;
    chk("t2_flush_no_hit", rd_data, 32'h23E0_0004);

    // Hit set racing a tdata1 write with hit=0: the write wins
    step(); mtch = 4'b0100; vld = 1'b1;
    step();
    wif.dbg_wr_valid = 1'b1; wif.dbg_wr_sel = 2'd2; wif.dbg_wr_data = 32'h0000_0004;
    #1;
    chk("race_fire", fire, 4'b0100);
    step(); rd_sel = 2'd2; #1;
    chk("race_hit_clear", rd_data, 32'h23E0_0004);

    // Match without D-stage valid is ignored
    step(); mtch = 4'b0100; vld = 1'b0;
    step(); #1;
    chk("invalid_no_fire", fire, 4'b0000);

    // Debug-mode action takes precedence
    wr1(1, 3, 0, 32'h0800_1004);
    step(); mtch = 4'b1000; vld = 1'b1;
    step(); #1;
    chk("t3_dbg_action", {fire, adbg, abrk}, 6'b1000_10);

    // Reset in the middle of a pending core write drops it
    step();
    wif.core_wr_valid = 1'b1; wif.core_wr_data = 32'h0000_0004;
    rst_l = 1'b0;
    #1;
    chk("midrst_ready", wif.core_wr_ready, 1'b0);
    chk("midrst_async_clear", rd_data, RO);
    step();
    rst_l = 1'b1;
    step(); #1;
    chk("midrst_write_dropped", rd_data, RO);

    // Randomized run against the register-image model
    for (int i = 0; i < 4; i++) begin m_t1[i] = RO; m_t2[i] = '0; end
    m_mr = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r_dv = ($urandom_range(0, 3) == 0);
      r_cv = ($urandom_range(0, 2) == 0);
      wif.dbg_wr_valid  = r_dv;  wif.dbg_wr_sel  = 2'($urandom_range(0, 3));
      wif.dbg_wr_reg    = 1'($urandom_range(0, 1)); wif.dbg_wr_data = $urandom;
      wif.core_wr_valid = r_cv;  wif.core_wr_sel = 2'($urandom_range(0, 3));
      wif.core_wr_reg   = 1'($urandom_range(0, 1)); wif.core_wr_data = $urandom;
      mtch  = 4'($urandom_range(0, 15));
      vld   = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      rd_sel = 2'($urandom_range(0, 3));
      rd_reg = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 3);
      #1;

      g_v   = r_dv | r_cv;
      g_dbg = r_dv;
      gs    = r_dv ? int'(wif.dbg_wr_sel) : int'(wif.core_wr_sel);
      g_r   = r_dv ? wif.dbg_wr_reg  : wif.core_wr_reg;
      g_d   = r_dv ? wif.dbg_wr_data : wif.core_wr_data;
      e_err = g_v && !g_dbg && m_t1[gs][27];

      f = m_mr;
      for (int e = 0; e < 4; e += 2)
        if (m_t1[e][11]) begin
          f[e]   = m_mr[e] & m_mr[e+1];
          f[e+1] = f[e];
        end
      fr = flush ? 4'b0 : f;
      e_dbg = 1'b0;
      for (int i = 0; i < 4; i++)
        if (fr[i] && m_t1[i][12]) e_dbg = 1'b1;
      e_brk = (fr != 4'b0) && !e_dbg;
      e_rd  = rd_reg ? m_t2[rd_sel] : m_t1[rd_sel];

      chk("rnd_handshake", {wif.dbg_wr_ready, wif.core_wr_ready, wif.wr_err}, {r_dv, r_cv & ~r_dv, e_err});
      chk("rnd_fire", fire, fr);
      chk("rnd_action", {adbg, abrk}, {e_dbg, e_brk});
      chk("rnd_rd_data", rd_data, e_rd);
      chk("rnd_pkt", {pkt[k].select, pkt[k].match, pkt[k].store, pkt[k].load,
                      pkt[k].execute, pkt[k].m, pkt[k].tdata2},
                     {m_t1[k][19], m_t1[k][7], m_t1[k][1], m_t1[k][0],
                      m_t1[k][2], m_t1[k][6], m_t2[k]});

      w1 = -1;
      if (g_v && !e_err) begin
        if (!g_r) begin
          v1 = g_d & WMSK;
          if (!g_dbg) v1[27] = 1'b0;
          if (!v1[27]) v1[12] = 1'b0;
          if (gs % 2 == 1) v1[11] = 1'b0;
          else if (m_t1[gs+1][27] && !v1[27]) v1[11] = 1'b0;
          m_t1[gs] = v1 | RO;
          w1 = gs;
        end else begin
          m_t2[gs] = g_d;
        end
      end
      for (int i = 0; i < 4; i++)
        if (fr[i] && i != w1) m_t1[i][20] = 1'b1;
      m_mr = vld ? mtch : 4'b0;
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mcu_el2_dec_trigger_ctl.md
Name: mcu_el2_dec_trigger_ctl

Overview:
Owns the four debug trigger register sets (mcontrol-style tdata1 plus tdata2) and drives trigger_pkt_any[3:0] into the decode-stage trigger matcher. Arbitrates CSR writes between the core CSR path and the debug module, and enforces dmode lock and chain-pair rules. Takes the raw per-trigger decode matches, registers them into R stage, applies chaining, sets hit bits and resolves the trigger action (debug-mode entry vs breakpoint exception).

Parameters:
NTRIG, 4, number of triggers; must be even, since chaining is pairwise (0/1, 2/3).
MASKMAX, 31, read-only maskmax field value returned in tdata1[26:21].

Ports:
clk  in  1  core clock
rst_l  in  1  reset, asynchronous, active-low
core_wr_valid  in  1  core CSR write request
core_wr_ready  out  1  core write accepted this cycle
dbg_wr_valid  in  1  debug-module write request
dbg_wr_ready  out  1  debug write accepted this cycle
core_wr_sel, dbg_wr_sel  in  2 each  tselect index
core_wr_reg, dbg_wr_reg  in  1 each  0=tdata1, 1=tdata2
core_wr_data, dbg_wr_data  in  32 each  write data
wr_err  out  1  pulse: accepted write was dropped because of dmode lock
rd_sel  in  2  read index
rd_reg  in  1  read register select
rd_data  out  32  combinational read data
trigger_pkt_any  out  NTRIG x mcu_el2_trigger_pkt_t  configuration to the matcher
i0_trigger_match_d  in  NTRIG  raw matches from the matcher
i0_valid_d  in  1  D-stage instruction valid
i0_flush_r  in  1  R-stage kill
trigger_fire_r  out  NTRIG  chain-qualified R-stage fires
trigger_action_dbg  out  1  fire requests debug-mode entry
trigger_action_brk  out  1  fire requests breakpoint exception

Behaviour:
- Reset: all tdata1/tdata2 fields 0; R-stage match register 0.
  - All outputs are 0 in reset except rd_data, which still reports the read-only fields.
- Arbitration is fixed priority, debug first.
  - dbg_wr_ready = dbg_wr_valid.
  - core_wr_ready = core_wr_valid & ~dbg_wr_valid.
  - No queueing: a core request losing arbitration holds until accepted.
- Write commit: a write accepted in cycle N updates the registers at the edge ending N. trigger_pkt_any reflects the new value in cycle N+1.
- Stored tdata1 fields: dmode[27], hit[20], select[19], action[12] (only 0/1 legal), chain[11], match[7] (0 = equal, 1 = NAPOT mask), m[6], execute[2], store[1], load[0].
  - Read-only fields: type[31:28]=2, maskmax=MASKMAX.
  - All other bits read 0.
- Write legality rules:
  - Core write to a trigger with dmode=1: dropped; ready still asserted; wr_err pulses 1 cycle.
  - Core write sets dmode to 0 regardless of data[27].
  - When the resulting dmode=0, action is forced to 0.
  - chain is writable only on even triggers; odd triggers read 0.
  - If the odd partner has dmode=1 and the even trigger has dmode=0, chain is forced to 0.
- tdata2 writes store all 32 bits. tdata2 is subject to the same dmode lock as tdata1.
- trigger_pkt_any[i] is mapped field by field from the stored registers. tdata2 passes unmodified.
- Match pipeline: match_r <= i0_trigger_match_d & {NTRIG{i0_valid_d}}. Latency is 1 cycle.
- Chaining, for pair (e, o=e+1) with chain[e]=1:
  - fire[e] = fire[o] = match_r[e] & match_r[o].
  - If chain[e]=0, fire equals match_r.
- trigger_fire_r = fire & ~{NTRIG{i0_flush_r}}.
- Action resolution:
  - trigger_action_dbg = |(trigger_fire_r & action).
  - trigger_action_brk = |trigger_fire_r & ~trigger_action_dbg. Debug takes precedence.
- Hit bit: hit[i] is set at the edge after trigger_fire_r[i]=1. If an accepted tdata1 write to trigger i occurs in the same cycle, the write value wins.
- Simultaneous core and debug writes to the same slot: only the debug write is accepted; the core request stays pending.
- Reset asserted mid-operation: the pending request is dropped silently. The requester must re-present it after reset.

Decomposition:
- mcu_el2_pkg: reuse mcu_el2_trigger_pkt_t. Add localparams for the tdata1 bit positions (dmode, hit, select, action, chain, match, m, execute, store, load) and TRIG_TYPE_MCONTROL=2.
- One sub-module, mcu_el2_trig_slot, instantiated NTRIG times. It holds one tdata1/tdata2 pair and applies the legality rules and hit-set priority. Inputs: granted write, debug-origin flag, partner dmode, fire.

Test Plan:
- Debug write tdata1[0]=0x0800_1044 (dmode=1, action=1, m=1, execute=1), then core write to tdata1[0] -> core write dropped, wr_err=1 for one cycle, rd_data[27]=1 retained.
- Both requesters valid in the same cycle -> dbg_wr_ready=1, core_wr_ready=0; next cycle the core request is accepted.
- chain[0]=1, i0_trigger_match_d=4'b0001 -> trigger_fire_r=0. Then match 4'b0011 -> fire=4'b0011 one cycle later, and hit[0]=hit[1]=1 the cycle after that.
- match 4'b0100 on trigger 2 with action=0 and i0_flush_r=0 -> trigger_action_brk=1, trigger_action_dbg=0. The same stimulus with i0_flush_r=1 -> no fire, and hit[2] stays 0.
- Core write tdata1 with action=1 -> reads back action=0 (dmode=0).
- Hit-set and a tdata1 write with hit=0 in the same cycle -> hit reads 0.
